// File: rtl/lsu_dmem_ctrl.sv
// Data-memory access controller: turns one LSU load/store into one or two
// word-aligned bus beats with byte strobes and returns aligned load data.
module lsu_dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_BEAT1 = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [31:0] wait_cnt;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] word0;
    logic [31:0] word1;
    logic        err;

    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic        misaligned;
    logic [7:0]  base_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] beat_base;
    logic        in_beat;
    logic        second;

    assign off = lat_addr[1:0];

    always_comb begin
        nbytes    = 3'd4;
        base_mask = 8'h0F;
        case (lat_size)
            2'b00: begin
                nbytes    = 3'd1;
                base_mask = 8'h01;
            end
            2'b01: begin
                nbytes    = 3'd2;
                base_mask = 8'h03;
            end
            default: begin
                nbytes    = 3'd4;
                base_mask = 8'h0F;
            end
        endcase
    end

    assign misaligned = ({1'b0, off} + nbytes) > 3'd4;
    assign lane_mask  = base_mask << off;
    assign lane_data  = {32'b0, lat_wdata} << {off, 3'b000};

    // The two captured words form a little-endian window that the byte offset slides over.
    assign shifted = 32'({word1, word0} >> {off, 3'b000});

    always_comb begin
        load_data = shifted;
        case (lat_size)
            2'b00:   load_data = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            word0     <= '0;
            word1     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        word0     <= '0;
                        word1     <= '0;
                        wait_cnt  <= '0;
                        err       <= (req_size == 2'b11);
                        state     <= (req_size == 2'b11) ? S_RESP : S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (mem_ready) begin
                        word0    <= mem_rdata;
                        wait_cnt <= '0;
                        if (mem_err) begin
                            err   <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            state <= misaligned ? S_GAP : S_RESP;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    wait_cnt <= '0;
                    state    <= S_BEAT1;
                end
                S_BEAT1: begin
                    if (mem_ready) begin
                        word1 <= mem_rdata;
                        err   <= err | mem_err;
                        state <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from the held request so they stay stable for the whole beat.
    assign in_beat   = (state == S_BEAT0) || (state == S_BEAT1);
    assign second    = (state == S_BEAT1);
    assign beat_base = {lat_addr[31:2], 2'b00} + (second ? 32'd4 : 32'd0);

    assign req_ready = (state == S_IDLE);
    assign mem_valid = in_beat;
    assign mem_we    = in_beat & lat_we;
    assign mem_addr  = in_beat ? beat_base : 32'd0;
    assign mem_wstrb = (in_beat & lat_we) ? (second ? lane_mask[7:4] : lane_mask[3:0]) : 4'b0000;
    assign mem_wdata = (in_beat & lat_we) ? (second ? lane_data[63:32] : lane_data[31:0]) : 32'd0;

    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = (state == S_RESP) & err;
    assign rsp_rdata = ((state == S_RESP) && !err && !lat_we) ? load_data : 32'd0;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed vector table, multi-cycle corner
// sequences, and random traffic checked against a byte-level memory model.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_err;

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_err(mem_err)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mem_arr [0:255];
    logic [7:0]  ref_mem [0:1023];

    int ready_mode = 0;
    int err_beat = -1;
    int wait_run = 0;

    logic [31:0] beat_addr [$];
    logic [3:0]  beat_strb [$];
    logic [31:0] beat_data [$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_beats;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs [15];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory slave: ready policy per mode, beats logged, strobed writes applied on acceptance.
    always @(negedge clk) begin
        logic rdy;
        rdy = 1'b0;
        if (!rst && mem_valid) begin
            check_output("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (wait_run >= 5) || ($urandom_range(0, 3) != 0);
                3:       rdy = (beat_addr.size() == 0);
                default: rdy = 1'b0;
            endcase
            if (rdy) begin
                mem_ready = 1'b1;
                mem_rdata = mem_arr[mem_addr[9:2]];
                mem_err   = (beat_addr.size() == err_beat);
                if (mem_we && !mem_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
                beat_addr.push_back(mem_addr);
                beat_strb.push_back(mem_wstrb);
                beat_data.push_back(mem_wdata);
                wait_run = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                mem_err   = 1'($urandom);
                wait_run++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = $urandom;
            wait_run  = 0;
        end
    end

    task automatic poke_word(input logic [31:0] addr, input logic [31:0] data);
        mem_arr[addr[9:2]] = data;
        for (int i = 0; i < 4; i++) ref_mem[{addr[9:2], 2'(i)}] = data[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int nb;
        logic [31:0] v;
        nb = 1 << size;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[10'(addr + 32'(i))];
        if (!uns) for (int i = 8 * nb; i < 32; i++) v[i] = v[8*nb-1];
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
    endtask

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (int'(addr[1:0]) + (1 << size)) > 4;
    endfunction

    task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check_output("req_ready_wait", 32'd0, 32'd1);
        beat_addr.delete();
        beat_strb.delete();
        beat_data.delete();
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        start_req(we, size, uns, addr, wdata);
        lat = 0;
        got = 0;
        rdata = '0;
        err = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1;
                rdata = rsp_rdata;
                err = rsp_err;
            end
        end
        if (!got) check_output("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          exp_beats;
        int          vcount;
        int          seen;
        bit          got;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) poke_word(32'(i * 4), $urandom);
        poke_word(32'h100, 32'hDEADBEEF);
        poke_word(32'h004, 32'h80011234);
        poke_word(32'h008, 32'h5566777F);

        #1;
        check_output("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check_output("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_output("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("reset_mem_addr", mem_addr, 32'd0);
        check_output("reset_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0, 32'hDEADBEEF, 1'b0, 1,
                     32'h00000100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h00000203, 32'h000000A5, 32'h0, 1'b0, 1,
                     32'h00000200, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h00000007, 32'h0, 32'h00007F80, 1'b0, 2,
                     32'h00000004, 4'h0, 32'h0, 32'h00000008, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h00000006, 32'h0, 32'hFFFF8001, 1'b0, 1,
                     32'h00000004, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0, 1'b0, 2,
                     32'hFFFFFFFC, 4'hC, 32'h33440000, 32'h00000000, 4'h3, 32'h00001122};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h11223344, 1'b0, 2,
                     32'hFFFFFFFC, 4'h0, 32'h0, 32'h00000000, 4'h0, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h00000203, 32'h0, 32'h000000A5, 1'b0, 1,
                     32'h00000200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h00000203, 32'h0, 32'hFFFFFFA5, 1'b0, 1,
                     32'h00000200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h00000100, 32'h0, 32'h0, 1'b1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 32'h00000040, 32'hFFFFFFFF, 32'h0, 1'b1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h00000102, 32'h0, 32'h0000DEAD, 1'b0, 1,
                     32'h00000100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h00000101, 32'hFFFFBEEF, 32'h0, 1'b0, 1,
                     32'h00000100, 4'h6, 32'hFFBEEF00, 32'h0, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0, 32'hDEBEEFEF, 1'b0, 1,
                     32'h00000100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h00000001, 32'hCAFEF00D, 32'h0, 1'b0, 2,
                     32'h00000000, 4'hE, 32'hFEF00D00, 32'h00000004, 4'h1, 32'h000000CA};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0, 32'hFEF00D22, 1'b0, 1,
                     32'h00000000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            ready_mode = 0;
            err_beat = -1;
            apply_stimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                           rdata, err, lat);
            check_output("vec_rdata", rdata, vecs[i].exp_rdata);
            check_output("vec_err", {31'b0, err}, {31'b0, vecs[i].exp_err});
            check_output("vec_latency", lat,
                         vecs[i].exp_beats == 0 ? 1 : (vecs[i].exp_beats == 1 ? 2 : 4));
            check_output("vec_beats", beat_addr.size(), vecs[i].exp_beats);
            @(negedge clk);
            check_output("vec_rsp_pulse", {31'b0, rsp_valid}, 32'd0);
            if (vecs[i].exp_beats >= 1 && beat_addr.size() >= 1) begin
                check_output("vec_beat0_addr", beat_addr[0], vecs[i].a0);
                check_output("vec_beat0_strb", {28'b0, beat_strb[0]}, {28'b0, vecs[i].s0});
                if (vecs[i].we) check_output("vec_beat0_data", beat_data[0], vecs[i].d0);
            end
            if (vecs[i].exp_beats == 2 && beat_addr.size() == 2) begin
                check_output("vec_beat1_addr", beat_addr[1], vecs[i].a1);
                check_output("vec_beat1_strb", {28'b0, beat_strb[1]}, {28'b0, vecs[i].s1});
                if (vecs[i].we) check_output("vec_beat1_data", beat_data[1], vecs[i].d1);
            end
            if (vecs[i].we && !vecs[i].exp_err) ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
        end

        // Bus never answers: each beat must give up after exactly 16 valid cycles.
        for (int k = 0; k < 2; k++) begin
            ready_mode = 2;
            err_beat = -1;
            start_req(1'b0, 2'd2, 1'b0, (k == 0) ? 32'h300 : 32'h301, 32'h0);
            lat = 0;
            vcount = 0;
            got = 0;
            while (!got && lat < 40) begin
                @(negedge clk);
                lat++;
                if (mem_valid) vcount++;
                if (rsp_valid) begin
                    got = 1;
                    rdata = rsp_rdata;
                    err = rsp_err;
                end
            end
            check_output("timeout_rsp_seen", {31'b0, got}, 32'd1);
            check_output("timeout_valid_cycles", vcount, 32'd16);
            check_output("timeout_latency", lat, 32'd17);
            check_output("timeout_err", {31'b0, err}, 32'd1);
            check_output("timeout_rdata", rdata, 32'd0);
        end
        ready_mode = 0;

        // Bus error on the first beat of a misaligned load suppresses the second beat.
        err_beat = 0;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rdata, err, lat);
        check_output("err0_err", {31'b0, err}, 32'd1);
        check_output("err0_rdata", rdata, 32'd0);
        check_output("err0_beats", beat_addr.size(), 32'd1);
        check_output("err0_latency", lat, 32'd2);

        err_beat = 1;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rdata, err, lat);
        check_output("err1_err", {31'b0, err}, 32'd1);
        check_output("err1_rdata", rdata, 32'd0);
        check_output("err1_beats", beat_addr.size(), 32'd2);
        check_output("err1_latency", lat, 32'd4);
        err_beat = -1;

        // Reset while the second beat is waiting on the bus.
        ready_mode = 3;
        start_req(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0);
        repeat (4) @(negedge clk);
        check_output("rstmid_beat1_valid", {31'b0, mem_valid}, 32'd1);
        check_output("rstmid_beat1_addr", mem_addr, 32'h400);
        #2;
        rst = 1'b1;
        #1;
        check_output("rstmid_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_output("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
        check_output("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("rstmid_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_output("rstmid_no_rsp", seen, 32'd0);
        ready_mode = 0;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rdata, err, lat);
        check_output("rstmid_next_rdata", rdata, 32'hDEBEEFEF);
        check_output("rstmid_next_err", {31'b0, err}, 32'd0);
        check_output("rstmid_next_latency", lat, 32'd2);

        // Random traffic against the byte-level model, with a stalling bus.
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns = 1'($urandom);
            addr = $urandom;
            wdata = $urandom;
            err_beat = -1;
            if (!we && size != 2'd3 && $urandom_range(0, 7) == 0)
                err_beat = ref_misaligned(addr, size) ? $urandom_range(0, 1) : 0;
            if (size == 2'd3) begin
                exp_err = 1'b1;
                exp_rdata = '0;
                exp_beats = 0;
            end else if (err_beat >= 0) begin
                exp_err = 1'b1;
                exp_rdata = '0;
                exp_beats = err_beat + 1;
            end else begin
                exp_err = 1'b0;
                exp_rdata = we ? 32'd0 : ref_load(addr, size, uns);
                exp_beats = ref_misaligned(addr, size) ? 2 : 1;
            end
            apply_stimulus(we, size, uns, addr, wdata, rdata, err, lat);
            if (we && !exp_err) ref_store(addr, size, wdata);
            check_output("rand_rdata", rdata, exp_rdata);
            check_output("rand_err", {31'b0, err}, {31'b0, exp_err});
            check_output("rand_beats", beat_addr.size(), exp_beats);
            for (int k = 0; k < beat_addr.size() && k < 2; k++)
                check_output("rand_beat_addr", beat_addr[k], {addr[31:2], 2'b00} + 32'(4 * k));
        end
        err_beat = -1;

        for (int w = 0; w < 256; w++)
            check_output("final_mem_word", mem_arr[w],
                         {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
